// File: rtl/fir_tap_feeder_pkg.sv
// Shared definitions for the FIR tap feeder and coefficient loader.
package fir_tap_feeder_pkg;

  typedef enum logic [1:0] {
    LDR_IDLE = 2'd0,
    LDR_LOAD = 2'd1,
    LDR_PEND = 2'd2
  } ldr_state_t;

  // Bits needed to count 0..taps inclusive.
  function automatic int unsigned idx_width(input int unsigned taps);
    return $clog2(taps + 1);
  endfunction

endpackage

// File: rtl/fir_coeff_loader.sv
// Serial coefficient loader: fills a shadow bank beat by beat and swaps it
// into the active bank when the parent signals a commit while pending.
module fir_coeff_loader
  import fir_tap_feeder_pkg::*;
#(
  parameter int unsigned FIR_LEN  = 21,
  parameter int unsigned NB_COEFF = 8
) (
  input  logic                         clk,
  input  logic                         i_reset,
  input  logic [NB_COEFF-1:0]          i_coeff_data,
  input  logic                         i_coeff_valid,
  input  logic                         i_coeff_last,
  input  logic                         i_commit,
  output logic                         o_coeff_ready,
  output logic [FIR_LEN*NB_COEFF-1:0]  o_coeff,
  output logic                         o_coeff_err
);

  localparam int unsigned           IDX_W    = idx_width(FIR_LEN);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(FIR_LEN - 1);

  ldr_state_t          state;
  logic [IDX_W-1:0]    idx;
  logic [NB_COEFF-1:0] shadow [FIR_LEN];
  logic                beat;

  // Ready is a registered mirror of (state != PEND).
  assign beat = i_coeff_valid && o_coeff_ready;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state         <= LDR_IDLE;
      idx           <= '0;
      o_coeff_ready <= 1'b1;
      o_coeff       <= '0;
      o_coeff_err   <= 1'b0;
      for (int unsigned k = 0; k < FIR_LEN; k++) shadow[k] <= '0;
    end else begin
      case (state)
        LDR_IDLE, LDR_LOAD: begin
          if (beat) begin
            if (i_coeff_last && (idx == LAST_IDX)) begin
              shadow[idx]   <= i_coeff_data;
              idx           <= '0;
              state         <= LDR_PEND;
              o_coeff_ready <= 1'b0;
            end else if (i_coeff_last || (idx == LAST_IDX)) begin
              // Wrong set length: drop the partial set and start over.
              o_coeff_err <= 1'b1;
              idx         <= '0;
              state       <= LDR_IDLE;
              for (int unsigned k = 0; k < FIR_LEN; k++) shadow[k] <= '0;
            end else begin
              shadow[idx] <= i_coeff_data;
              idx         <= idx + IDX_W'(1);
              state       <= LDR_LOAD;
            end
          end
        end
        LDR_PEND: begin
          if (i_commit) begin
            for (int unsigned k = 0; k < FIR_LEN; k++)
              o_coeff[k*NB_COEFF +: NB_COEFF] <= shadow[k];
            state         <= LDR_IDLE;
            o_coeff_ready <= 1'b1;
          end
        end
        default: begin
          state         <= LDR_IDLE;
          idx           <= '0;
          o_coeff_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/fir_tap_feeder.sv
// FIR input stage: sample delay line with fill tracking, plus a coefficient
// loader whose bank swap is aligned to the next accepted sample.
module fir_tap_feeder
  import fir_tap_feeder_pkg::*;
#(
  parameter int unsigned FIR_LEN  = 21,
  parameter int unsigned NB_IN    = 8,
  parameter int unsigned NB_COEFF = 8
) (
  input  logic                         clk,
  input  logic                         i_reset,
  input  logic                         i_en,
  input  logic [NB_IN-1:0]             i_sample,
  input  logic                         i_sample_valid,
  output logic [FIR_LEN*NB_IN-1:0]     o_data_reg,
  output logic                         o_valid,
  output logic                         o_fill,
  input  logic [NB_COEFF-1:0]          i_coeff_data,
  input  logic                         i_coeff_valid,
  input  logic                         i_coeff_last,
  output logic                         o_coeff_ready,
  output logic [FIR_LEN*NB_COEFF-1:0]  o_coeff,
  output logic                         o_coeff_err
);

  localparam int unsigned      CNT_W    = idx_width(FIR_LEN);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIR_LEN);

  logic             sample_accept;
  logic [CNT_W-1:0] count;

  assign sample_accept = i_en && i_sample_valid;

  // Delay line shift, valid pulse and saturating fill count.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_data_reg <= '0;
      o_valid    <= 1'b0;
      o_fill     <= 1'b0;
      count      <= '0;
    end else begin
      o_valid <= sample_accept;
      if (sample_accept) begin
        o_data_reg[NB_IN-1:0] <= i_sample;
        for (int unsigned k = 1; k < FIR_LEN; k++)
          o_data_reg[k*NB_IN +: NB_IN] <= o_data_reg[(k-1)*NB_IN +: NB_IN];
        if (count != CNT_FULL) begin
          count <= count + CNT_W'(1);
          if (count == (CNT_FULL - CNT_W'(1))) o_fill <= 1'b1;
        end
      end
    end
  end

  fir_coeff_loader #(
    .FIR_LEN  (FIR_LEN),
    .NB_COEFF (NB_COEFF)
  ) u_loader (
    .clk           (clk),
    .i_reset       (i_reset),
    .i_coeff_data  (i_coeff_data),
    .i_coeff_valid (i_coeff_valid),
    .i_coeff_last  (i_coeff_last),
    .i_commit      (sample_accept),
    .o_coeff_ready (o_coeff_ready),
    .o_coeff       (o_coeff),
    .o_coeff_err   (o_coeff_err)
  );

endmodule

// File: tb/tb_fir_tap_feeder.sv
// Scoreboard bench for fir_tap_feeder: expected delay-line images are queued
// when a sample is driven and checked when o_valid reports the shift.
module tb_fir_tap_feeder;

  localparam int unsigned FIR_LEN  = 21;
  localparam int unsigned NB_IN    = 8;
  localparam int unsigned NB_COEFF = 8;
  localparam int unsigned DW       = FIR_LEN * NB_IN;
  localparam int unsigned CW       = FIR_LEN * NB_COEFF;

  logic                clk = 1'b0;
  logic                i_reset;
  logic                i_en;
  logic [NB_IN-1:0]    i_sample;
  logic                i_sample_valid;
  logic [DW-1:0]       o_data_reg;
  logic                o_valid;
  logic                o_fill;
  logic [NB_COEFF-1:0] i_coeff_data;
  logic                i_coeff_valid;
  logic                i_coeff_last;
  logic                o_coeff_ready;
  logic [CW-1:0]       o_coeff;
  logic                o_coeff_err;

  logic [DW-1:0] model_taps;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_taps;
  logic [CW-1:0] exp_coeff;
  int            n_checks = 0;
  int            n_pass   = 0;

  always #5 clk = ~clk;

  fir_tap_feeder #(
    .FIR_LEN  (FIR_LEN),
    .NB_IN    (NB_IN),
    .NB_COEFF (NB_COEFF)
  ) dut (
    .clk            (clk),
    .i_reset        (i_reset),
    .i_en           (i_en),
    .i_sample       (i_sample),
    .i_sample_valid (i_sample_valid),
    .o_data_reg     (o_data_reg),
    .o_valid        (o_valid),
    .o_fill         (o_fill),
    .i_coeff_data   (i_coeff_data),
    .i_coeff_valid  (i_coeff_valid),
    .i_coeff_last   (i_coeff_last),
    .o_coeff_ready  (o_coeff_ready),
    .o_coeff        (o_coeff),
    .o_coeff_err    (o_coeff_err)
  );

  function automatic logic [CW-1:0] ramp(input logic [7:0] base);
    logic [CW-1:0] r;
    for (int k = 0; k < int'(FIR_LEN); k++) r[k*NB_COEFF +: NB_COEFF] = 8'(base + 8'(k));
    return r;
  endfunction

  // Drive one cycle of inputs; accepted samples update the model and queue.
  task automatic step(input logic en, input logic sv, input logic [7:0] s,
                      input logic cv, input logic [7:0] cd, input logic cl);
    i_en = en; i_sample_valid = sv; i_sample = s;
    i_coeff_valid = cv; i_coeff_data = cd; i_coeff_last = cl;
    if (en && sv) begin
      model_taps = {model_taps[DW-NB_IN-1:0], s};
      exp_q.push_back(model_taps);
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    i_reset = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    i_reset = 1'b0;
    model_taps = '0;
    exp_q.delete();
    exp_coeff = '0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_en = 1'b1; i_sample_valid = 1'b1; i_sample = 8'h55;
    i_coeff_valid = 1'b1; i_coeff_data = 8'h66; i_coeff_last = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (o_data_reg !== '0) $display("FAIL reset_data got %h want 0", o_data_reg); else n_pass++;
    n_checks++;
    if (o_valid !== 1'b0 || o_fill !== 1'b0) $display("FAIL reset_valid_fill got %b%b want 00", o_valid, o_fill); else n_pass++;
    n_checks++;
    if (o_coeff !== '0 || o_coeff_err !== 1'b0) $display("FAIL reset_coeff got %h err %b want 0", o_coeff, o_coeff_err); else n_pass++;
    i_reset = 1'b0;
    model_taps = '0;
    exp_q.delete();
    exp_coeff = '0;
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if (o_coeff_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", o_coeff_ready); else n_pass++;
    n_checks++;
    if (o_valid !== 1'b0) $display("FAIL reset_no_valid got %b want 0", o_valid); else n_pass++;
  endtask

  task automatic test_shift();
    for (int i = 1; i <= 25; i++) begin
      step(1'b1, 1'b1, 8'(i), 1'b0, 8'h00, 1'b0);
      n_checks++;
      if (o_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL shift_valid i=%0d got %b want 1", i, o_valid);
      else begin
        exp_taps = exp_q.pop_front();
        if (o_data_reg !== exp_taps) $display("FAIL shift_data i=%0d got %h want %h", i, o_data_reg, exp_taps);
        else n_pass++;
      end
      n_checks++;
      if (o_fill !== (i >= 21)) $display("FAIL shift_fill i=%0d got %b want %b", i, o_fill, (i >= 21)); else n_pass++;
    end
    for (int k = 0; k < int'(FIR_LEN); k++) begin
      n_checks++;
      if (o_data_reg[k*NB_IN +: NB_IN] !== 8'(25 - k))
        $display("FAIL shift_tap%0d got %0d want %0d", k, o_data_reg[k*NB_IN +: NB_IN], 25 - k);
      else n_pass++;
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if (o_valid !== 1'b0 || o_data_reg !== model_taps) $display("FAIL shift_hold valid %b data %h want 0 %h", o_valid, o_data_reg, model_taps); else n_pass++;
  endtask

  task automatic test_gated();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
      n_checks++;
      if (o_valid !== 1'b0 || o_data_reg !== model_taps)
        $display("FAIL gated c=%0d valid %b data %h want 0 %h", i, o_valid, o_data_reg, model_taps);
      else n_pass++;
    end
  endtask

  task automatic test_good_load();
    for (int b = 0; b < int'(FIR_LEN); b++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 8'(8'h01 + 8'(b)), (b == 20));
      n_checks++;
      if (o_coeff !== exp_coeff) $display("FAIL good_early_coeff b=%0d got %h want %h", b, o_coeff, exp_coeff); else n_pass++;
      n_checks++;
      if (o_coeff_ready !== (b != 20)) $display("FAIL good_ready b=%0d got %b want %b", b, o_coeff_ready, (b != 20)); else n_pass++;
    end
    // Beats offered while pending must be ignored.
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'hEE, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if (o_coeff_ready !== 1'b0 || o_coeff !== exp_coeff || o_coeff_err !== 1'b0)
      $display("FAIL good_pend ready %b err %b coeff %h want 0 0 %h", o_coeff_ready, o_coeff_err, o_coeff, exp_coeff);
    else n_pass++;
    step(1'b1, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0);
    exp_coeff = ramp(8'h01);
    n_checks++;
    if (o_coeff !== exp_coeff) $display("FAIL good_commit got %h want %h", o_coeff, exp_coeff); else n_pass++;
    n_checks++;
    if (o_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL good_sb_valid got %b want 1", o_valid);
    else begin
      exp_taps = exp_q.pop_front();
      if (o_data_reg !== exp_taps) $display("FAIL good_sb_data got %h want %h", o_data_reg, exp_taps); else n_pass++;
    end
    n_checks++;
    if (o_coeff_ready !== 1'b1 || o_coeff_err !== 1'b0) $display("FAIL good_after ready %b err %b want 1 0", o_coeff_ready, o_coeff_err); else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 20; b++) step(1'b0, 1'b0, 8'h00, 1'b1, 8'(8'h40 + 8'(b)), 1'b0);
    step(1'b1, 1'b1, 8'h11, 1'b1, 8'h54, 1'b1);
    n_checks++;
    if (o_coeff !== exp_coeff || o_coeff_ready !== 1'b0)
      $display("FAIL b2b_no_commit coeff %h ready %b want %h 0", o_coeff, o_coeff_ready, exp_coeff);
    else n_pass++;
    n_checks++;
    if (o_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL b2b_sb_valid got %b want 1", o_valid);
    else begin
      exp_taps = exp_q.pop_front();
      if (o_data_reg !== exp_taps) $display("FAIL b2b_sb_data got %h want %h", o_data_reg, exp_taps); else n_pass++;
    end
    step(1'b1, 1'b1, 8'h22, 1'b0, 8'h00, 1'b0);
    exp_coeff = ramp(8'h40);
    n_checks++;
    if (o_coeff !== exp_coeff) $display("FAIL b2b_commit got %h want %h", o_coeff, exp_coeff); else n_pass++;
    n_checks++;
    if (o_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL b2b_sb2_valid got %b want 1", o_valid);
    else begin
      exp_taps = exp_q.pop_front();
      if (o_data_reg !== exp_taps) $display("FAIL b2b_sb2_data got %h want %h", o_data_reg, exp_taps); else n_pass++;
    end
  endtask

  task automatic test_short_err();
    for (int b = 0; b < 10; b++) step(1'b0, 1'b0, 8'h00, 1'b1, 8'(8'h90 + 8'(b)), (b == 9));
    n_checks++;
    if (o_coeff_err !== 1'b1 || o_coeff_ready !== 1'b1)
      $display("FAIL short_err err %b ready %b want 1 1", o_coeff_err, o_coeff_ready);
    else n_pass++;
    step(1'b1, 1'b1, 8'h33, 1'b0, 8'h00, 1'b0);
    void'(exp_q.pop_front());
    n_checks++;
    if (o_coeff !== exp_coeff) $display("FAIL short_keep got %h want %h", o_coeff, exp_coeff); else n_pass++;
    for (int b = 0; b < int'(FIR_LEN); b++) step(1'b0, 1'b0, 8'h00, 1'b1, 8'(8'hA0 + 8'(b)), (b == 20));
    step(1'b1, 1'b1, 8'h44, 1'b0, 8'h00, 1'b0);
    void'(exp_q.pop_front());
    exp_coeff = ramp(8'hA0);
    n_checks++;
    if (o_coeff !== exp_coeff || o_coeff_err !== 1'b1)
      $display("FAIL short_recommit coeff %h err %b want %h 1", o_coeff, o_coeff_err, exp_coeff);
    else n_pass++;
  endtask

  task automatic test_long_err();
    apply_reset();
    for (int b = 0; b < int'(FIR_LEN); b++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 8'(8'hB0 + 8'(b)), 1'b0);
      n_checks++;
      if (o_coeff_err !== (b == 20)) $display("FAIL long_err b=%0d got %b want %b", b, o_coeff_err, (b == 20)); else n_pass++;
    end
    n_checks++;
    if (o_coeff_ready !== 1'b1) $display("FAIL long_ready got %b want 1", o_coeff_ready); else n_pass++;
    // The next beat must land at index 0 of a fresh set.
    for (int b = 0; b < int'(FIR_LEN); b++) step(1'b0, 1'b0, 8'h00, 1'b1, 8'(8'hC0 + 8'(b)), (b == 20));
    n_checks++;
    if (o_coeff_ready !== 1'b0 || o_coeff !== '0) $display("FAIL long_pend ready %b coeff %h want 0 0", o_coeff_ready, o_coeff); else n_pass++;
    step(1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0);
    void'(exp_q.pop_front());
    exp_coeff = ramp(8'hC0);
    n_checks++;
    if (o_coeff !== exp_coeff || o_coeff_err !== 1'b1)
      $display("FAIL long_commit coeff %h err %b want %h 1", o_coeff, o_coeff_err, exp_coeff);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    for (int b = 0; b < int'(FIR_LEN); b++) step(1'b0, 1'b0, 8'h00, 1'b1, 8'(8'hD0 + 8'(b)), (b == 20));
    n_checks++;
    if (o_coeff_ready !== 1'b0) $display("FAIL mid_pend ready got %b want 0", o_coeff_ready); else n_pass++;
    i_reset = 1'b1;
    i_en = 1'b1; i_sample_valid = 1'b1; i_sample = 8'h99;
    i_coeff_valid = 1'b0; i_coeff_last = 1'b0;
    @(posedge clk); #1;
    i_reset = 1'b0;
    model_taps = '0;
    exp_q.delete();
    exp_coeff = '0;
    n_checks++;
    if (o_coeff !== '0 || o_coeff_err !== 1'b0) $display("FAIL mid_coeff coeff %h err %b want 0 0", o_coeff, o_coeff_err); else n_pass++;
    n_checks++;
    if (o_data_reg !== '0 || o_valid !== 1'b0 || o_fill !== 1'b0)
      $display("FAIL mid_data data %h valid %b fill %b want 0", o_data_reg, o_valid, o_fill);
    else n_pass++;
    n_checks++;
    if (o_coeff_ready !== 1'b1) $display("FAIL mid_ready got %b want 1", o_coeff_ready); else n_pass++;
    step(1'b1, 1'b1, 8'h7E, 1'b0, 8'h00, 1'b0);
    n_checks++;
    if (o_coeff !== '0 || o_coeff_ready !== 1'b1) $display("FAIL mid_abandon coeff %h ready %b want 0 1", o_coeff, o_coeff_ready); else n_pass++;
    n_checks++;
    if (o_valid !== 1'b1 || exp_q.size() == 0) $display("FAIL mid_sb_valid got %b want 1", o_valid);
    else begin
      exp_taps = exp_q.pop_front();
      if (o_data_reg !== exp_taps) $display("FAIL mid_sb_data got %h want %h", o_data_reg, exp_taps); else n_pass++;
    end
  endtask

  initial begin
    i_reset = 1'b0; i_en = 1'b0; i_sample = '0; i_sample_valid = 1'b0;
    i_coeff_data = '0; i_coeff_valid = 1'b0; i_coeff_last = 1'b0;
    model_taps = '0;
    exp_coeff = '0;
    @(negedge clk);
    test_reset();
    test_shift();
    test_gated();
    test_good_load();
    test_back_to_back();
    test_short_err();
    test_long_err();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_tap_feeder.md
FIR_TAP_FEEDER -- requirements
Module: fir_tap_feeder

Interface
REQ-001 The block SHALL have parameter FIR_LEN, default 21, number of taps.
REQ-002 The block SHALL have parameter NB_IN, default 8, sample width (signed).
REQ-003 The block SHALL have parameter NB_COEFF, default 8, coefficient width (signed).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port i_en, input, 1, global enable.
REQ-007 The block SHALL have port i_sample, input, NB_IN, new signed sample.
REQ-008 The block SHALL have port i_sample_valid, input, 1, sample qualifier.
REQ-009 The block SHALL have port o_data_reg, output, FIR_LEN*NB_IN, packed delay line; tap k at [k*NB_IN +: NB_IN], k=0 newest.
REQ-010 The block SHALL have port o_valid, output, 1, one-cycle pulse after each delay-line shift.
REQ-011 The block SHALL have port o_fill, output, 1, high once FIR_LEN samples have been accepted since reset.
REQ-012 The block SHALL have port i_coeff_data, input, NB_COEFF, serial coefficient beat.
REQ-013 The block SHALL have port i_coeff_valid, input, 1, beat qualifier.
REQ-014 The block SHALL have port i_coeff_last, input, 1, marks the final beat of a set.
REQ-015 The block SHALL have port o_coeff_ready, output, 1, loader accepts a beat.
REQ-016 The block SHALL have port o_coeff, output, FIR_LEN*NB_COEFF, active coefficient bank; coefficient k at [k*NB_COEFF +: NB_COEFF].
REQ-017 The block SHALL have port o_coeff_err, output, 1, sticky load-length error.

Function
REQ-018 The block SHALL accept a sample when i_en && i_sample_valid; on that edge tap 0 <= i_sample and tap k <= tap k-1, with tap FIR_LEN-1 discarded.
REQ-019 The block SHALL hold o_data_reg unchanged in cycles with no accepted sample.
REQ-020 The block SHALL register o_valid high for exactly the cycle after each accepted sample, giving 1-cycle latency.
REQ-021 The block SHALL count accepted samples, saturating at FIR_LEN, and drive o_fill = (count == FIR_LEN).
REQ-022 The loader SHALL implement states IDLE, LOAD, and PEND.
REQ-023 In IDLE and LOAD, o_coeff_ready SHALL be 1; in PEND it SHALL be 0.
REQ-024 A beat SHALL transfer on i_coeff_valid && o_coeff_ready, independent of i_en.
REQ-025 A transferred beat SHALL be written to shadow[idx], with idx starting at 0 and then incrementing, and SHALL move IDLE to LOAD.
REQ-026 A beat with last and idx == FIR_LEN-1 SHALL go to PEND.
REQ-027 A beat with last and idx < FIR_LEN-1 SHALL set o_coeff_err, discard the shadow contents, and go to IDLE with idx = 0.
REQ-028 A beat at idx == FIR_LEN-1 without last SHALL set o_coeff_err, discard the shadow contents, and go to IDLE with idx = 0.
REQ-029 In PEND, on the next accepted sample edge, shadow SHALL be copied to o_coeff on that same edge, so that the new data and new coefficients appear together, and the state SHALL return to IDLE.
REQ-030 o_coeff SHALL change only at a PEND commit.
REQ-031 o_coeff_err SHALL clear only on reset.
REQ-032 A sample accepted on the same edge as the final beat SHALL NOT commit; commit SHALL require a later sample.
REQ-033 With FIR_LEN=1, the first beat SHALL require last.
REQ-034 Arithmetic SHALL be limited to width-clean index and count counters of $clog2(FIR_LEN+1) bits; no sample or coefficient arithmetic.

Reset
REQ-035 When i_reset=1 at a clock edge, the block SHALL clear o_data_reg, o_coeff, and shadow to all zeros.
REQ-036 When i_reset=1 at a clock edge, the block SHALL clear o_valid, o_fill, and o_coeff_err to 0.
REQ-037 When i_reset=1 at a clock edge, the block SHALL clear the count and idx to 0 and set the state to IDLE.
REQ-038 Reset SHALL take priority over all other inputs on that edge.
REQ-039 Reset mid-load or in PEND SHALL abandon the set without any commit.
REQ-040 o_coeff_ready SHALL be 1 in the cycle after reset is released.

Structure
REQ-041 The loader state encodings (IDLE=0, LOAD=1, PEND=2) and the index-width function SHALL live in a shared header included by the feeder and by fir.
REQ-042 The loader SHALL be a sub-module fir_coeff_loader that owns the FSM, idx, shadow, active bank, and error flag, and takes a commit strobe from the parent.
REQ-043 The delay line, o_valid, and the fill count SHALL stay in fir_tap_feeder.

Verification
REQ-044 Shift test: after reset, feed samples 1..25 on consecutive cycles with i_en=1 -> o_valid high every cycle from cycle 2, o_fill rises after the 21st sample, final taps 0..20 = 25..5.
REQ-045 Gated-input test: hold i_sample_valid=1 with i_en=0 for 5 cycles -> o_data_reg and o_valid stay constant/0.
REQ-046 Good-load test: send 21 beats (values 0x01..0x15, last on the 21st) then one sample -> o_coeff unchanged until the sample edge, then coefficient k = k+1; o_coeff_ready low only in PEND.
REQ-047 Short-set error test: send last on beat 10 -> o_coeff_err=1, o_coeff stays at its previous value; a following valid 21-beat load still commits and o_coeff_err stays 1.
REQ-048 Long-set error test: send 21 beats without last -> error raised on the 21st beat; the 22nd beat is accepted as idx 0 of a new set.
REQ-049 Mid-load reset test: assert i_reset in PEND -> next cycle o_coeff=0, state IDLE, o_coeff_err=0, o_data_reg=0.
